// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops cfg_len words from a registered-read FIFO and replays them
// as a valid/ready stream with m_last, using a 2-entry buffer to hide the read latency.
module fifo_stream_reader #(
    parameter int WIDTH     = 64,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] cfg_len,
    output logic                 busy,
    output logic                 done,
    output logic                 fifo_rd_en,
    input  logic [WIDTH-1:0]     fifo_dout,
    input  logic                 fifo_empty,
    output logic                 m_valid,
    output logic [WIDTH-1:0]     m_data,
    output logic                 m_last,
    input  logic                 m_ready
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [LEN_WIDTH-1:0] one = 1;
    state_t state, state_nxt;
    logic [LEN_WIDTH-1:0] len, issued, sent;
    logic [WIDTH-1:0] head, tail;
    logic [1:0] occ;
    logic inflight, fire, last_fire, run;
    assign run        = state == RUN;
    assign busy       = run;
    assign m_valid    = occ != 2'd0;
    assign m_data     = head;
    assign m_last     = m_valid && sent == len - one;
    assign fire       = m_valid & m_ready;
    assign last_fire  = fire & m_last;
    // the word already in flight from the FIFO reserves a buffer slot
    assign fifo_rd_en = run & !fifo_empty & (issued < len) &
                        (({1'b0, occ} + {2'b0, inflight} - {2'b0, fire}) < 3'd2);
    always_comb begin
        state_nxt = state;
        if (state == IDLE && start && cfg_len != '0)
            state_nxt = RUN;
        else if (run && last_fire)
            state_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            len      <= '0;
            issued   <= '0;
            sent     <= '0;
            inflight <= 1'b0;
            occ      <= 2'd0;
            head     <= '0;
            tail     <= '0;
        end else begin
            state    <= state_nxt;
            done     <= (state == IDLE && start && cfg_len == '0) || (run && last_fire);
            inflight <= fifo_rd_en;
            if (state == IDLE && start) begin
                len    <= cfg_len;
                issued <= '0;
                sent   <= '0;
            end
            if (fifo_rd_en)
                issued <= issued + one;
            if (fire)
                sent <= sent + one;
            case ({inflight, fire})
                2'b10: begin
                    if (occ == 2'd0)
                        head <= fifo_dout;
                    else
                        tail <= fifo_dout;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1)
                        head <= fifo_dout;
                    else begin
                        head <= tail;
                        tail <= fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: random-ready scoreboard bench for fifo_stream_reader against a
// queue-based FIFO/stream model.
module tb_fifo_stream_reader;
    logic        clk = 0;
    logic        rst_n;
    logic        start;
    logic [15:0] cfg_len;
    logic        busy, done, fifo_rd_en, fifo_empty, m_valid, m_last, m_ready;
    logic [63:0] fifo_dout, m_data;

    fifo_stream_reader #(.WIDTH(64), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .busy(busy), .done(done),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, n_fire = 0, pops = 0, mode = 0;
    int wr_ptr = 0, rd_ptr = 0, owed = 0;
    logic [63:0] mem [0:1023];
    logic [63:0] model_q[$];
    logic [64:0] exp_q[$];

    // FIFO model with registered read data
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= 0;
            fifo_dout <= '0;
        end else if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr % 1024];
            rd_ptr    <= rd_ptr + 1;
            pops      <= pops + 1;
        end
    end

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void feed();
        while (owed > 0 && model_q.size() > 0) begin
            owed--;
            exp_q.push_back({owed == 0, model_q.pop_front()});
        end
    endfunction

    task automatic write_word(input logic [63:0] d);
        mem[wr_ptr % 1024] = d;
        wr_ptr++;
        model_q.push_back(d);
        feed();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start(input int len, input bit accepted);
        cfg_len = 16'(len);
        start   = 1;
        step();
        start   = 0;
        if (accepted) begin
            owed = len;
            feed();
        end
    endtask

    task automatic wait_done(input string nm, input int trickle);
        bit got = 0;
        int w = 0;
        for (int c = 0; c < 400; c++) begin
            if (done) begin
                got = 1;
                break;
            end
            if (w < trickle && c % 3 == 0) begin
                write_word(64'hA0 + 64'(w));
                w++;
            end
            step();
        end
        chk({nm, "_done"}, 65'(got), 65'd1);
        chk({nm, "_all_words"}, 65'(exp_q.size()), 65'd0);
        step();
        chk({nm, "_done_one_cycle"}, 65'(done), 65'd0);
        chk({nm, "_idle"}, 65'(busy), 65'd0);
    endtask

    // sink ready generator
    initial begin
        int k = 0;
        m_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 4 == 0 || k % 4 == 3) : 1'($urandom_range(0, 1));
            k++;
        end
    end

    // monitor: scoreboard compare, hold rule, no pop from empty FIFO
    initial begin
        bit prev_stall = 0;
        logic [63:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) prev_stall = 0;
            else begin
                if (prev_stall) begin
                    chk("hold_valid", 65'(m_valid), 65'd1);
                    chk("hold_data", {1'b0, m_data}, {1'b0, prev_data});
                end
                if (fifo_rd_en) chk("rd_en_while_empty", 65'(fifo_empty), 65'd0);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %h expected none", m_data);
                    end else chk("word", {m_last, m_data}, exp_q.pop_front());
                    n_fire++;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
            end
        end
    end

    initial begin
        int p0, base;
        rst_n = 0; start = 0; cfg_len = 0;
        #12;
        chk("rst_busy", 65'(busy), 65'd0);
        chk("rst_done", 65'(done), 65'd0);
        chk("rst_valid", 65'(m_valid), 65'd0);
        chk("rst_data", {1'b0, m_data}, 65'd0);
        chk("rst_last", 65'(m_last), 65'd0);
        chk("rst_rd_en", 65'(fifo_rd_en), 65'd0);
        step();
        rst_n = 1;
        step();

        // full-rate transfer with latency check
        mode = 0;
        for (int i = 0; i < 8; i++) write_word(64'h10 + 64'(i));
        p0 = pops;
        pulse_start(8, 1);
        chk("t1_busy", 65'(busy), 65'd1);
        chk("t1_rd_en_e0", 65'(fifo_rd_en), 65'd1);
        chk("t1_valid_e0", 65'(m_valid), 65'd0);
        step();
        chk("t1_valid_e1", 65'(m_valid), 65'd0);
        step();
        chk("t1_valid_e2", 65'(m_valid), 65'd1);
        base = n_fire;
        wait_done("t1", 0);
        chk("t1_pops", 65'(pops - p0), 65'd8);

        // stalling sink
        mode = 1;
        for (int i = 0; i < 8; i++) write_word(64'h10 + 64'(i));
        p0 = pops;
        pulse_start(8, 1);
        wait_done("t2", 0);
        chk("t2_pops", 65'(pops - p0), 65'd8);

        // FIFO starts empty, trickle writes
        mode = 0;
        p0 = pops;
        pulse_start(4, 1);
        wait_done("t3", 4);
        chk("t3_pops", 65'(pops - p0), 65'd4);

        // zero and one word transfers
        write_word(64'h55);
        p0 = pops;
        pulse_start(0, 1);
        chk("t4_len0_done", 65'(done), 65'd1);
        chk("t4_len0_busy", 65'(busy), 65'd0);
        step();
        chk("t4_len0_pops", 65'(pops - p0), 65'd0);
        chk("t4_len0_valid", 65'(m_valid), 65'd0);
        pulse_start(1, 1);
        wait_done("t4_len1", 0);
        chk("t4_len1_pops", 65'(pops - p0), 65'd1);

        // randomized transfers with random ready
        mode = 2;
        for (int t = 0; t < 6; t++) begin
            int len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) write_word({$urandom, $urandom});
            p0 = pops;
            pulse_start(len, 1);
            wait_done("rand", 0);
            chk("rand_pops", 65'(pops - p0), 65'(len));
        end

        // start during RUN is ignored
        mode = 0;
        for (int i = 0; i < 12; i++) write_word(64'hC0 + 64'(i));
        p0 = pops;
        pulse_start(5, 1);
        step();
        pulse_start(99, 0);
        wait_done("t5", 0);
        chk("t5_pops", 65'(pops - p0), 65'd5);
        chk("t5_fifo_left", 65'(wr_ptr - rd_ptr), 65'd7);

        // async reset mid-transfer
        for (int i = 0; i < 8; i++) write_word(64'hE0 + 64'(i));
        base = n_fire;
        pulse_start(8, 1);
        for (int c = 0; c < 100 && n_fire - base < 3; c++) step();
        chk("t6_three_fired", 65'(n_fire - base), 65'd3);
        rst_n = 0;
        wr_ptr = 0;
        model_q.delete();
        exp_q.delete();
        owed = 0;
        #1;
        chk("t6_rst_busy", 65'(busy), 65'd0);
        chk("t6_rst_valid", 65'(m_valid), 65'd0);
        chk("t6_rst_data", {1'b0, m_data}, 65'd0);
        chk("t6_rst_last", 65'(m_last), 65'd0);
        chk("t6_rst_rd_en", 65'(fifo_rd_en), 65'd0);
        chk("t6_rst_done", 65'(done), 65'd0);
        step();
        rst_n = 1;
        step();
        chk("t6_idle", 65'(busy), 65'd0);
        write_word(64'h77);
        write_word(64'h78);
        p0 = pops;
        pulse_start(2, 1);
        wait_done("t6_after", 0);
        chk("t6_pops", 65'(pops - p0), 65'd2);

        chk("final_queue_empty", 65'(exp_q.size()), 65'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
